// File: rtl/rr_sched_pkg.sv
// Shared types for the record/replay host-buffer scheduler: FSM states,
// descriptor layout and direction encodings.
package rr_sched_pkg;

  localparam int unsigned RR_DESC_W = 64;

  typedef enum logic [1:0] {
    RR_IDLE,
    RR_LOAD,
    RR_ACTIVE,
    RR_STARVED
  } rr_sched_state_t;

  typedef struct packed {
    logic [RR_DESC_W-1:0] addr;
    logic [RR_DESC_W-1:0] size;
  } rr_buf_desc_t;

  localparam logic RR_DIR_WRITE = 1'b0;
  localparam logic RR_DIR_READ  = 1'b1;

endpackage

// File: rtl/rr_buf_desc_fifo.sv
// DEPTH-entry synchronous FIFO of buffer descriptors. Push while full and
// pop while empty are ignored.
module rr_buf_desc_fifo
  import rr_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  rr_buf_desc_t desc_i,
  input  logic         pop_i,
  output rr_buf_desc_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rr_buf_desc_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= desc_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rr_trace_buf_sched.sv
// Host-buffer scheduler: queues record/replay descriptors per direction and
// feeds them to the trace engine, one per buffer-consumed interrupt.
module rr_trace_buf_sched
  import rr_sched_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sched_enable,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic                      desc_dir,
  input  logic [AXI_ADDR_WIDTH-1:0] desc_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] desc_size,
  output logic [AXI_ADDR_WIDTH-1:0] write_buf_addr,
  output logic [AXI_ADDR_WIDTH-1:0] write_buf_size,
  output logic                      write_buf_update,
  input  logic                      write_interrupt,
  output logic [AXI_ADDR_WIDTH-1:0] read_buf_addr,
  output logic [AXI_ADDR_WIDTH-1:0] read_buf_size,
  output logic                      read_buf_update,
  input  logic                      read_interrupt,
  output logic [CNT_WIDTH-1:0]      wr_done_cnt,
  output logic [CNT_WIDTH-1:0]      rd_done_cnt,
  output logic                      wr_starved,
  output logic                      rd_starved,
  output logic                      err
);

  logic [1:0]                irq, upd, full_v, starved_v, bad_irq;
  logic [AXI_ADDR_WIDTH-1:0] buf_addr [2];
  logic [AXI_ADDR_WIDTH-1:0] buf_size [2];
  logic [CNT_WIDTH-1:0]      done_cnt [2];
  logic                      push_ok, zero_push, push_nz;
  rr_buf_desc_t              push_desc;
  logic                      err_q;

  assign irq        = {read_interrupt, write_interrupt};
  assign desc_ready = !full_v[desc_dir];
  assign push_ok    = desc_valid && desc_ready;
  assign zero_push  = push_ok && (desc_size == '0);
  assign push_nz    = push_ok && (desc_size != '0);

  always_comb begin
    push_desc = '0;
    push_desc.addr[AXI_ADDR_WIDTH-1:0] = desc_addr;
    push_desc.size[AXI_ADDR_WIDTH-1:0] = desc_size;
  end

  for (genvar d = 0; d < 2; d++) begin : g_dir
    rr_sched_state_t           state_q, state_d;
    rr_buf_desc_t              head;
    logic                      full, empty, push, pop, done;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, size_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic                      starved_q;

    assign push = push_nz && (desc_dir == 1'(d));

    rr_buf_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .desc_i  (push_desc),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
    );

    // The pop happens on the edge entering LOAD, so the descriptor is
    // already on the output registers for the whole LOAD cycle.
    always_comb begin
      state_d = state_q;
      done    = (state_q == RR_ACTIVE) && irq[d];
      unique case (state_q)
        RR_IDLE:    if (!empty) state_d = RR_LOAD;
        RR_LOAD:    state_d = RR_ACTIVE;
        RR_ACTIVE:  if (irq[d]) state_d = empty ? RR_STARVED : RR_LOAD;
        RR_STARVED: if (!empty) state_d = RR_LOAD;
        default:    state_d = RR_IDLE;
      endcase
      if (!sched_enable) state_d = RR_IDLE;
      pop = (state_d == RR_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= RR_IDLE;
        addr_q    <= '0;
        size_q    <= '0;
        cnt_q     <= '0;
        starved_q <= 1'b0;
      end else begin
        state_q <= state_d;
        if (pop) begin
          addr_q <= head.addr[AXI_ADDR_WIDTH-1:0];
          size_q <= head.size[AXI_ADDR_WIDTH-1:0];
        end
        if (done)          cnt_q     <= cnt_q + CNT_WIDTH'(1);
        if (done && empty) starved_q <= 1'b1;
      end
    end

    assign upd[d]       = (state_q == RR_LOAD);
    assign full_v[d]    = full;
    assign starved_v[d] = starved_q;
    assign bad_irq[d]   = irq[d] && (state_q != RR_ACTIVE);
    assign buf_addr[d]  = addr_q;
    assign buf_size[d]  = size_q;
    assign done_cnt[d]  = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        err_q <= 1'b0;
    else if (zero_push || |bad_irq) err_q <= 1'b1;
  end

  assign write_buf_addr   = buf_addr[RR_DIR_WRITE];
  assign write_buf_size   = buf_size[RR_DIR_WRITE];
  assign write_buf_update = upd[RR_DIR_WRITE];
  assign read_buf_addr    = buf_addr[RR_DIR_READ];
  assign read_buf_size    = buf_size[RR_DIR_READ];
  assign read_buf_update  = upd[RR_DIR_READ];
  assign wr_done_cnt      = done_cnt[RR_DIR_WRITE];
  assign rd_done_cnt      = done_cnt[RR_DIR_READ];
  assign wr_starved       = starved_v[RR_DIR_WRITE];
  assign rd_starved       = starved_v[RR_DIR_READ];
  assign err              = err_q;

endmodule

// File: tb/tb_rr_trace_buf_sched.sv
// Bench for rr_trace_buf_sched: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_rr_trace_buf_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 64;
  localparam int unsigned CW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sched_enable = 1'b0, desc_valid = 1'b0, desc_dir = 1'b0;
  logic          desc_ready;
  logic [AW-1:0] desc_addr = '0, desc_size = '0;
  logic [AW-1:0] write_buf_addr, write_buf_size, read_buf_addr, read_buf_size;
  logic          write_buf_update, read_buf_update;
  logic          write_interrupt = 1'b0, read_interrupt = 1'b0;
  logic [CW-1:0] wr_done_cnt, rd_done_cnt;
  logic          wr_starved, rd_starved, err;

  always #5 clk = ~clk;

  rr_trace_buf_sched #(.DEPTH(DEPTH), .AXI_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .sched_enable     (sched_enable),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .desc_dir         (desc_dir),
    .desc_addr        (desc_addr),
    .desc_size        (desc_size),
    .write_buf_addr   (write_buf_addr),
    .write_buf_size   (write_buf_size),
    .write_buf_update (write_buf_update),
    .write_interrupt  (write_interrupt),
    .read_buf_addr    (read_buf_addr),
    .read_buf_size    (read_buf_size),
    .read_buf_update  (read_buf_update),
    .read_interrupt   (read_interrupt),
    .wr_done_cnt      (wr_done_cnt),
    .rd_done_cnt      (rd_done_cnt),
    .wr_starved       (wr_starved),
    .rd_starved       (rd_starved),
    .err              (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue per direction, plus "update this cycle" and
  // "engine owns a buffer" flags. Starved and idle behave identically here.
  logic [63:0] qa [2][$];
  logic [63:0] qs [2][$];
  bit          m_load [2];
  bit          m_hold [2];
  logic [63:0] m_addr [2];
  logic [63:0] m_size [2];
  logic [CW-1:0] m_cnt [2];
  bit          m_starv [2];
  bit          m_err;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      qa[d].delete(); qs[d].delete();
      m_load[d] = 0; m_hold[d] = 0; m_addr[d] = '0; m_size[d] = '0;
      m_cnt[d] = '0; m_starv[d] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input bit dir,
                            input logic [63:0] a, input logic [63:0] s,
                            input bit wi, input bit ri);
    bit irq [2];
    bit full_pre [2];
    bit ne [2];
    bit want, nh;
    irq[0] = wi; irq[1] = ri;
    for (int d = 0; d < 2; d++) begin
      full_pre[d] = (qa[d].size() == DEPTH);
      ne[d]       = (qa[d].size() != 0);
    end
    for (int d = 0; d < 2; d++) begin
      if (irq[d] && !m_hold[d]) m_err = 1;
      if (irq[d] && m_hold[d]) begin
        m_cnt[d] = m_cnt[d] + 1;
        if (!ne[d]) m_starv[d] = 1;
      end
      want = en && ne[d] && ((!m_hold[d] && !m_load[d]) || (m_hold[d] && irq[d]));
      nh   = en && (m_load[d] || (m_hold[d] && !irq[d]));
      m_load[d] = want;
      m_hold[d] = nh;
      if (want) begin
        m_addr[d] = qa[d].pop_front();
        m_size[d] = qs[d].pop_front();
      end
    end
    if (v && !full_pre[dir]) begin
      if (s == 0) m_err = 1;
      else begin
        qa[dir].push_back(a);
        qs[dir].push_back(s);
      end
    end
  endtask

  task automatic check_all();
    chk("w_update",  write_buf_update, m_load[0]);
    chk("r_update",  read_buf_update,  m_load[1]);
    chk("w_addr",    write_buf_addr,   m_addr[0]);
    chk("w_size",    write_buf_size,   m_size[0]);
    chk("r_addr",    read_buf_addr,    m_addr[1]);
    chk("r_size",    read_buf_size,    m_size[1]);
    chk("wr_cnt",    wr_done_cnt,      m_cnt[0]);
    chk("rd_cnt",    rd_done_cnt,      m_cnt[1]);
    chk("wr_starv",  wr_starved,       m_starv[0]);
    chk("rd_starv",  rd_starved,       m_starv[1]);
    chk("err",       err,              m_err);
    chk("ready",     desc_ready,       qa[desc_dir].size() < DEPTH);
  endtask

  task automatic cyc(input bit en, input bit v, input bit dir,
                     input logic [63:0] a, input logic [63:0] s,
                     input bit wi, input bit ri);
    sched_enable = en; desc_valid = v; desc_dir = dir;
    desc_addr = a; desc_size = s;
    write_interrupt = wi; read_interrupt = ri;
    @(posedge clk);
    model_step(en, v, dir, a, s, wi, ri);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(en, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sched_enable = 0; desc_valid = 0; desc_dir = 0; desc_addr = '0; desc_size = '0;
    write_interrupt = 0; read_interrupt = 0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // 1: single write descriptor, enabled after the push
    do_reset();
    cyc(0, 1, 0, 64'h1000_0000, 64'd1024, 0, 0);
    cyc(1, 0, 0, '0, '0, 0, 0);
    chk("s1_upd",  write_buf_update, 1);
    chk("s1_addr", write_buf_addr, 64'h1000_0000);
    chk("s1_size", write_buf_size, 64'd1024);
    idle(4, 1);
    chk("s1_rupd", read_buf_update, 0);

    // 2: four descriptors, three interrupts
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 0, 64'h2000_0000 + 64'(i) * 64'h100, 64'd256 + 64'(i), 0, 0);
    for (int k = 0; k < 3; k++) begin
      idle(9, 1);
      cyc(1, 0, 0, '0, '0, 1, 0);
    end
    idle(3, 1);
    chk("s2_cnt",  wr_done_cnt, 3);
    chk("s2_addr", write_buf_addr, 64'h2000_0300);

    // 3: starvation and recovery
    do_reset();
    cyc(1, 1, 0, 64'h3000_0000, 64'd64, 0, 0);
    idle(3, 1);
    cyc(1, 0, 0, '0, '0, 1, 0);
    idle(2, 1);
    cyc(1, 0, 0, '0, '0, 1, 0);
    idle(2, 1);
    chk("s3_starv", wr_starved, 1);
    chk("s3_cnt1",  wr_done_cnt, 1);
    cyc(1, 1, 0, 64'h3100_0000, 64'd128, 0, 0);
    cyc(1, 0, 0, '0, '0, 0, 0);
    chk("s3_upd",  write_buf_update, 1);
    chk("s3_addr", write_buf_addr, 64'h3100_0000);
    idle(3, 1);
    cyc(1, 0, 0, '0, '0, 1, 0);
    idle(2, 1);
    chk("s3_cnt2", wr_done_cnt, 2);

    // 4: full read queue, zero-size push
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 1, 64'h4000_0000 + 64'(i) * 64'h10, 64'd32, 0, 0);
    cyc(0, 0, 1, '0, '0, 0, 0);
    chk("s4_rdy_r", desc_ready, 0);
    cyc(0, 0, 0, '0, '0, 0, 0);
    chk("s4_rdy_w", desc_ready, 1);
    cyc(0, 1, 0, 64'h4100_0000, 64'd0, 0, 0);
    chk("s4_err", err, 1);
    idle(3, 1);
    chk("s4_wupd", write_buf_update, 0);

    // 5: simultaneous interrupts on both sides
    do_reset();
    cyc(1, 1, 0, 64'h5000_0000, 64'd16, 0, 0);
    cyc(1, 1, 1, 64'h5100_0000, 64'd17, 0, 0);
    cyc(1, 1, 0, 64'h5000_1000, 64'd18, 0, 0);
    cyc(1, 1, 1, 64'h5100_1000, 64'd19, 0, 0);
    idle(3, 1);
    cyc(1, 0, 0, '0, '0, 1, 1);
    chk("s5_wupd", write_buf_update, 1);
    chk("s5_rupd", read_buf_update, 1);
    chk("s5_wcnt", wr_done_cnt, 1);
    chk("s5_rcnt", rd_done_cnt, 1);

    // 6: reset asserted during LOAD
    do_reset();
    cyc(1, 1, 0, 64'h6000_0000, 64'd8, 0, 0);
    cyc(1, 0, 0, '0, '0, 0, 0);
    chk("s6_load", write_buf_update, 1);
    do_reset();
    chk("s6_upd0", write_buf_update, 0);
    idle(5, 1);
    cyc(1, 1, 0, 64'h6100_0000, 64'd9, 0, 0);
    cyc(1, 0, 0, '0, '0, 0, 0);
    chk("s6_upd1", write_buf_update, 1);
    chk("s6_addr", write_buf_addr, 64'h6100_0000);

    // random traffic, reset between blocks so err stays informative
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        bit en, v, dir, wi, ri;
        logic [63:0] a, s;
        en  = ($urandom_range(0, 31) != 0);
        v   = ($urandom_range(0, 1) == 1);
        dir = 1'($urandom_range(0, 1));
        a   = {$urandom, $urandom};
        s   = ($urandom_range(0, 15) == 0) ? 64'd0 : ({32'd0, $urandom} | 64'd1);
        wi  = m_hold[0] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
        ri  = m_hold[1] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
        cyc(en, v, dir, a, s, wi, ri);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_trace_buf_sched.md
# rr_trace_buf_sched

Host-buffer scheduler for the record/replay trace datapath. It sits between the host-side descriptor interface and the buffer-configuration ports of `rr_trace_rw`. It queues host memory buffer descriptors separately for the record (write) and replay (read) directions. It hands each descriptor to the trace engine with a one-cycle `*_buf_update` pulse, and issues the next descriptor when the engine raises its buffer-consumed interrupt.

## Interface
- `DEPTH`, 4: descriptors queued per direction; power of two, 2..16.
- `AXI_ADDR_WIDTH`, 64: address/size width.
- `CNT_WIDTH`, 32: width of completion counters.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sched_enable`  in  1  level; 0 holds both directions in IDLE.
- `desc_valid`  in  1  descriptor push valid.
- `desc_ready`  out  1  high when the FIFO selected by `desc_dir` is not full.
- `desc_dir`  in  1  0 = record/write, 1 = replay/read.
- `desc_addr`  in  AXI_ADDR_WIDTH  buffer base address, byte.
- `desc_size`  in  AXI_ADDR_WIDTH  buffer size, byte; 0 is illegal.
- `write_buf_addr`, `write_buf_size`  out  AXI_ADDR_WIDTH  descriptor to the trace engine write side.
- `write_buf_update`  out  1  one-cycle load strobe.
- `write_interrupt`  in  1  engine finished the current write buffer.
- `read_buf_addr`, `read_buf_size`, `read_buf_update`, `read_interrupt`  same as above, read side.
- `wr_done_cnt`, `rd_done_cnt`  out  CNT_WIDTH  buffers completed.
- `wr_starved`, `rd_starved`  out  1  sticky: interrupt arrived with an empty queue.
- `err`  out  1  sticky: zero-size descriptor or interrupt outside ACTIVE.

## Operation
- Handshake: a push occurs when `desc_valid && desc_ready`. A zero-size push is accepted and dropped, and sets `err`. Queue contents are unchanged.
- Each direction runs an identical, independent FSM: IDLE, LOAD, ACTIVE, STARVED.
  - IDLE → LOAD when `sched_enable` is high and the queue is non-empty.
  - LOAD: pop the head, register addr/size onto `*_buf_addr`/`*_buf_size`, pulse `*_buf_update` for one cycle, then go to ACTIVE.
  - ACTIVE: on `*_interrupt`, increment `*_done_cnt`. Go to LOAD if the queue is non-empty, otherwise go to STARVED and set `*_starved`.
  - STARVED → LOAD when the queue becomes non-empty.
  - Deasserting `sched_enable` forces IDLE from any state on the next edge. Already-loaded engine state is not revoked.
- An interrupt in IDLE, LOAD or STARVED is ignored, except that it sets `err`.
- `*_buf_addr`/`*_buf_size` hold their last loaded value until the next LOAD.
- `*_done_cnt` wraps modulo 2^CNT_WIDTH.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: all outputs are 0 except `desc_ready`, which is 1. FSMs reset to IDLE. FIFOs reset to empty.
- Push-to-queue latency is 1 cycle: a descriptor pushed at edge t is visible as non-empty at edge t+1.
- IDLE with enable and a non-empty queue at edge t: LOAD during cycle t+1, `*_buf_update` high during cycle t+1 with addr/size valid the same cycle.
- Interrupt sampled at edge t with a non-empty queue: `*_buf_update` high in cycle t+1. The counter increments at edge t.
- Back-to-back interrupts: the second one arrives during LOAD and is flagged as `err`.
- A push into the queue being popped in the same cycle is legal. When full, `desc_ready` drops the cycle after the last slot fills and rises the cycle after a pop.
- `rst` mid-operation clears FSMs, queues, counters and flags immediately, with no update pulse issued.

## Structure
- Shared package (`rr_sched_pkg`): FSM state enum `rr_sched_state_t`, descriptor struct `rr_buf_desc_t` {addr, size}, direction constants `RR_DIR_WRITE`/`RR_DIR_READ`.
- Sub-module `rr_buf_desc_fifo`: DEPTH-entry synchronous FIFO of `rr_buf_desc_t` with push/pop/full/empty. Instantiate it once per direction.
- The per-direction FSM is a generate loop or a duplicated always block in the top level.

## Test plan
- Reset, then push write desc {0x1000_0000, 1024}, then enable → `write_buf_update` pulses once with that addr/size 2 cycles after the push. `read_buf_update` stays 0.
- Push 4 write descriptors, 3 interrupts spaced 10 cycles apart → 4 update pulses in push order, `wr_done_cnt` = 3, FSM ends ACTIVE.
- One descriptor, 2 interrupts → `wr_starved` = 1. A later push gives an update 2 cycles after the push and `wr_done_cnt` = 2.
- Fill the read queue (4 pushes) → `desc_ready` = 0 for dir=1 but 1 for dir=0. Also push with `desc_size` = 0 → `err` = 1 and the queue count is unchanged.
- Interleave write and read interrupts in the same cycle → both updates fire in the same next cycle and each counter increments by 1.
- Assert `rst` during LOAD → `write_buf_update` goes low immediately, all counters are 0, and no update occurs after release until re-enable with a new push.
